// File: rtl/acc_share_pkg.sv
// Shared definitions for the accumulator-sharing arbiter: state encoding and
// default datapath sizes.
package acc_share_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BLOCK_LEN = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FEED = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/acc_share_arbiter_rr_pick.sv
// Two-way round-robin selector: the requester that did not win last time is
// preferred, otherwise whichever one is requesting.
module acc_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic pref_s;

    // Preference flips away from the previous winner.
    always_comb begin
        pref_s      = ~last_grant_i;
        gnt_valid_o = |req_i;
        if (req_i[pref_s]) begin
            gnt_id_o = pref_s;
        end else begin
            gnt_id_o = ~pref_s;
        end
    end

endmodule

// File: rtl/acc_share_arbiter.sv
// Shares one block accumulator between two requester streams: a requester owns
// the actor for a full block, and the single result is routed back to it.
module acc_share_arbiter
    import acc_share_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int CNT_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in0_empty,
    input  logic [DATA_W-1:0] in0,
    output logic              in0_rd,
    input  logic              in1_empty,
    input  logic [DATA_W-1:0] in1,
    output logic              in1_rd,
    output logic              acc_in_empty,
    output logic [DATA_W-1:0] acc_in_data,
    input  logic              acc_in_rd,
    input  logic [DATA_W-1:0] acc_out_data,
    input  logic              acc_out_wr,
    output logic              acc_out_full,
    input  logic              out0_full,
    output logic [DATA_W-1:0] out0,
    output logic              out0_wr,
    input  logic              out1_full,
    output logic [DATA_W-1:0] out1,
    output logic              out1_wr,
    output logic              owner,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic own_empty_s, own_full_s;
    logic gnt_valid_s, gnt_id_s;
    logic in_xfer_s, out_xfer_s;

    acc_rr_pick u_pick (
        .req_i        ({~in1_empty, ~in0_empty}),
        .last_grant_i (last_q),
        .gnt_valid_o  (gnt_valid_s),
        .gnt_id_o     (gnt_id_s)
    );

    // Handshake steering: only the owner's FIFOs ever see rd/wr or data.
    always_comb begin
        own_empty_s  = owner_q ? in1_empty : in0_empty;
        own_full_s   = owner_q ? out1_full : out0_full;
        in0_rd       = 1'b0;
        in1_rd       = 1'b0;
        out0_wr      = 1'b0;
        out1_wr      = 1'b0;
        out0         = '0;
        out1         = '0;
        acc_in_empty = 1'b1;
        acc_in_data  = '0;
        acc_out_full = 1'b1;
        case (state_q)
            ST_FEED: begin
                acc_in_empty = own_empty_s;
                acc_in_data  = owner_q ? in1 : in0;
                if (owner_q) begin
                    in1_rd = acc_in_rd & ~own_empty_s;
                end else begin
                    in0_rd = acc_in_rd & ~own_empty_s;
                end
            end
            ST_WAIT: begin
                acc_out_full = own_full_s;
                if (owner_q) begin
                    out1    = acc_out_data;
                    out1_wr = acc_out_wr & ~own_full_s;
                end else begin
                    out0    = acc_out_data;
                    out0_wr = acc_out_wr & ~own_full_s;
                end
            end
            default: begin
            end
        endcase
    end

    assign in_xfer_s  = (state_q == ST_FEED) & acc_in_rd & ~own_empty_s;
    assign out_xfer_s = (state_q == ST_WAIT) & acc_out_wr & ~own_full_s;

    // Next-state: grant in IDLE, count a block in FEED, release on result delivery.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q | (acc_in_rd & acc_in_empty) | (acc_out_wr & acc_out_full);
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    owner_d = gnt_id_s;
                    count_d = '0;
                    state_d = ST_FEED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (in_xfer_s && (count_q == LAST_CNT)) begin
                    state_d = ST_WAIT;
                end else if (in_xfer_s) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    state_d = ST_FEED;
                end
            end
            ST_WAIT: begin
                if (out_xfer_s) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q != ST_IDLE);
    assign err   = err_q;

endmodule
